sram_controller: RTL and testbench

SRAM_CONTROLLER -- requirements
Module: sram_controller

---
 rtl/sram_controller.sv | 103 ++++++++++
 tb/tb_sram_controller.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/sram_controller.sv
// MEM-stage SRAM controller: fixed-latency single-word read/write
// access, stalling the pipeline through ready until completion.
module sram_controller #(
    parameter int unsigned WAIT_CYCLES = 5,
    parameter int unsigned BASE_ADDR   = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rd_en,
    input  logic        wr_en,
    input  logic [31:0] address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data,
    output logic        ready,
    output logic [16:0] sram_addr,
    output logic [31:0] sram_dq_out,
    output logic        sram_dq_oe,
    input  logic [31:0] sram_dq_in,
    output logic        sram_we_n
);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE
    } state_t;

    state_t     state;
    state_t     state_nx;
    logic [3:0] cnt;
    logic       op_wr;
    logic       last;
    logic       req;

    assign req  = rd_en | wr_en;
    assign last = (cnt == 4'(WAIT_CYCLES - 1));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Strobes decode from state so an async reset drops them at once.
    always_comb begin
        state_nx   = state;
        ready      = 1'b1;
        sram_we_n  = 1'b1;
        sram_dq_oe = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    ready    = 1'b0;
                    state_nx = ACCESS;
                end
            end
            ACCESS: begin
                ready      = 1'b0;
                sram_we_n  = ~op_wr;
                sram_dq_oe = op_wr;
                if (last) begin
                    state_nx = DONE;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (!rst) begin
            ready = 1'b1;
        end
    end

    // Write wins when both requests are raised together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt         <= '0;
            op_wr       <= 1'b0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            read_data   <= '0;
        end else begin
            if (state == IDLE && req) begin
                cnt         <= '0;
                op_wr       <= wr_en;
                sram_addr   <= 17'((address - 32'(BASE_ADDR)) >> 2);
                sram_dq_out <= write_data;
            end else if (state == ACCESS) begin
                if (!last) begin
                    cnt <= cnt + 4'd1;
                end else if (!op_wr) begin
                    read_data <= sram_dq_in;
                end
            end
        end
    end

endmodule

// File: tb/tb_sram_controller.sv
// Directed bench for sram_controller: WAIT_CYCLES=5 and
// WAIT_CYCLES=1 instances, hand-computed expectations.
module tb_sram_controller;

    logic        clk = 1'b0;
    logic        rst;
    logic        rd_en, wr_en;
    logic [31:0] address, write_data, read_data, sram_dq_out, sram_dq_in;
    logic        ready, sram_dq_oe, sram_we_n;
    logic [16:0] sram_addr;

    logic        rd1, wr1;
    logic [31:0] addr1, wd1, rdata1, dqo1, dqi1;
    logic        rdy1, oe1, we1;
    logic [16:0] saddr1;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    sram_controller #(.WAIT_CYCLES(5), .BASE_ADDR(1024)) dut (
        .clk(clk), .rst(rst), .rd_en(rd_en), .wr_en(wr_en),
        .address(address), .write_data(write_data),
        .read_data(read_data), .ready(ready), .sram_addr(sram_addr),
        .sram_dq_out(sram_dq_out), .sram_dq_oe(sram_dq_oe),
        .sram_dq_in(sram_dq_in), .sram_we_n(sram_we_n)
    );

    sram_controller #(.WAIT_CYCLES(1), .BASE_ADDR(1024)) dut1 (
        .clk(clk), .rst(rst), .rd_en(rd1), .wr_en(wr1),
        .address(addr1), .write_data(wd1),
        .read_data(rdata1), .ready(rdy1), .sram_addr(saddr1),
        .sram_dq_out(dqo1), .sram_dq_oe(oe1),
        .sram_dq_in(dqi1), .sram_we_n(we1)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Drives one request, counts ready-low and write-strobe cycles and
    // returns one cycle after DONE with the request dropped.
    task automatic run_req(input logic r, input logic w,
                           input logic [31:0] a, input logic [31:0] wd,
                           input logic [31:0] dqi, input logic [16:0] ea,
                           output int lows, output int wes,
                           output int errs);
        rd_en = r;
        wr_en = w;
        address = a;
        write_data = wd;
        sram_dq_in = dqi;
        lows = 0;
        wes = 0;
        errs = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (ready) break;
            if (lows > 0 && sram_addr !== ea) errs++;
            if (!sram_we_n) begin
                wes++;
                if (!sram_dq_oe || sram_dq_out !== wd) errs++;
            end else if (sram_dq_oe) begin
                errs++;
            end
            lows++;
            @(negedge clk);
        end
        rd_en = 1'b0;
        wr_en = 1'b0;
        @(negedge clk);
    endtask

    int lows, wes, errs, n, t0, gap, highs;

    initial begin
        rst = 1'b0;
        rd_en = 1'b1;
        wr_en = 1'b0;
        address = 32'h400;
        write_data = '0;
        sram_dq_in = '0;
        rd1 = 1'b0;
        wr1 = 1'b0;
        addr1 = 32'h400;
        wd1 = '0;
        dqi1 = '0;
        repeat (3) @(negedge clk);
        chk("rst_ready", 32'(ready), 32'd1);
        chk("rst_rdata", read_data, 32'h0);
        chk("rst_addr", 32'(sram_addr), 32'h0);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_oe", 32'(sram_dq_oe), 32'd0);
        chk("rst_dqo", sram_dq_out, 32'h0);
        rd_en = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        #1 chk("idle_ready", 32'(ready), 32'd1);
        @(negedge clk);

        run_req(1'b1, 1'b0, 32'h408, 32'h0, 32'hDEADBEEF, 17'd2,
                lows, wes, errs);
        chk("rd_lows", 32'(lows), 32'd6);
        chk("rd_wes", 32'(wes), 32'd0);
        chk("rd_errs", 32'(errs), 32'd0);
        chk("rd_data", read_data, 32'hDEADBEEF);
        chk("rd_addr", 32'(sram_addr), 32'd2);

        run_req(1'b0, 1'b1, 32'h400, 32'h12345678, 32'h0BAD0BAD, 17'd0,
                lows, wes, errs);
        chk("wr_lows", 32'(lows), 32'd6);
        chk("wr_wes", 32'(wes), 32'd5);
        chk("wr_errs", 32'(errs), 32'd0);
        chk("wr_dqo", sram_dq_out, 32'h12345678);
        chk("wr_rdata", read_data, 32'hDEADBEEF);
        chk("wr_addr", 32'(sram_addr), 32'd0);

        run_req(1'b1, 1'b1, 32'h410, 32'hA5A5A5A5, 32'h11111111, 17'd4,
                lows, wes, errs);
        chk("both_wes", 32'(wes), 32'd5);
        chk("both_errs", 32'(errs), 32'd0);
        chk("both_rdata", read_data, 32'hDEADBEEF);
        chk("both_addr", 32'(sram_addr), 32'd4);

        // Reset on the third ACCESS cycle of a write
        wr_en = 1'b1;
        address = 32'h420;
        write_data = 32'hFEEDFACE;
        repeat (3) @(negedge clk);
        #1 chk("mid_we_pre", 32'(sram_we_n), 32'd0);
        rst = 1'b0;
        #1;
        chk("mid_we_n", 32'(sram_we_n), 32'd1);
        chk("mid_ready", 32'(ready), 32'd1);
        chk("mid_oe", 32'(sram_dq_oe), 32'd0);
        wr_en = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        #1 chk("post_ready", 32'(ready), 32'd1);
        chk("post_rdata", read_data, 32'h0);
        run_req(1'b1, 1'b0, 32'h40C, 32'h0, 32'hCAFEF00D, 17'd3,
                lows, wes, errs);
        chk("post_lows", 32'(lows), 32'd6);
        chk("post_data", read_data, 32'hCAFEF00D);

        // Back-to-back reads with the request held
        rd_en = 1'b1;
        address = 32'h404;
        sram_dq_in = 32'h01010101;
        n = 0;
        t0 = -1;
        gap = -1;
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            #1;
            if (ready) begin
                highs++;
                if (t0 < 0) begin
                    t0 = i;
                    chk("b2b_data1", read_data, 32'h01010101);
                    chk("b2b_addr1", 32'(sram_addr), 32'd1);
                    address = 32'h40C;
                    sram_dq_in = 32'h02020202;
                end else begin
                    gap = i - t0;
                    break;
                end
            end
            @(negedge clk);
        end
        chk("b2b_gap", 32'(gap), 32'd7);
        chk("b2b_highs", 32'(highs), 32'd2);
        chk("b2b_data2", read_data, 32'h02020202);
        chk("b2b_addr2", 32'(sram_addr), 32'd3);
        rd_en = 1'b0;
        @(negedge clk);

        // WAIT_CYCLES=1 instance
        rd1 = 1'b1;
        addr1 = 32'h414;
        dqi1 = 32'h5A5A5A5A;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rdy1) break;
            n++;
            @(negedge clk);
        end
        chk("w1_lows", 32'(n), 32'd2);
        chk("w1_data", rdata1, 32'h5A5A5A5A);
        chk("w1_addr", 32'(saddr1), 32'd5);
        rd1 = 1'b0;
        @(negedge clk);

        // Address below BASE_ADDR wraps to the top word
        rd1 = 1'b1;
        addr1 = 32'h3FC;
        dqi1 = 32'h77777777;
        n = 0;
        for (int i = 0; i < 20; i++) begin
            #1;
            if (rdy1) break;
            n++;
            @(negedge clk);
        end
        chk("wrap_lows", 32'(n), 32'd2);
        chk("wrap_addr", 32'(saddr1), 32'h1FFFF);
        chk("wrap_data", rdata1, 32'h77777777);
        rd1 = 1'b0;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
